// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-way, 4-set cache controller: geometry, FSM encoding and helpers.
package cache_ctrl_pkg;

  localparam int unsigned OFF_W    = 2;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned NUM_SETS = 1 << IDX_W;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_RESP   = 3'd2,
    S_WB     = 3'd3,
    S_REFILL = 3'd4,
    S_RWAIT  = 3'd5,
    S_FILL   = 3'd6
  } state_e;

  // First invalid way wins (way0 first); with both valid the LRU way is evicted.
  function automatic logic pick_victim(input logic v0, input logic v1, input logic lru_way);
    if (!v0)      return 1'b0;
    else if (!v1) return 1'b1;
    else          return lru_way;
  endfunction

endpackage

// File: rtl/cache_ctrl_lru.sv
// Per-set 1-bit LRU state: each bit names the way to evict next in that set.
module cache_ctrl_lru
  import cache_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             lru_way_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             mru_way
);

  logic [NUM_SETS-1:0] lru_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q <= '0;
    end else if (upd_en) begin
      lru_q[upd_idx] <= ~mru_way;
    end
  end

  assign lru_way_c = lru_q[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Blocking single-request cache controller for a 2-way, 4-set, one-word-per-line cache_array.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 28,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arr_write_en,
  output logic [IDX_W-1:0]  arr_index,
  output logic              arr_victim_way,
  output logic              arr_v_in,
  output logic              arr_dirty_in,
  output logic [TAG_W-1:0]  arr_tag_in,
  output logic [DATA_W-1:0] arr_data_in,
  input  logic              v_way0,
  input  logic              v_way1,
  input  logic              dirty_way0,
  input  logic              dirty_way1,
  input  logic [TAG_W-1:0]  tag_way0,
  input  logic [TAG_W-1:0]  tag_way1,
  input  logic [DATA_W-1:0] data_way0,
  input  logic [DATA_W-1:0] data_way1,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TAG_LSB = IDX_W + OFF_W;

  state_e state, next_state;

  // Latched request
  logic              we_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;

  // Victim and refill capture
  logic              vic_way_q, vic_way_d;
  logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
  logic [DATA_W-1:0] vic_data_q, vic_data_d;
  logic [DATA_W-1:0] refill_q;

  logic              hit0, hit1, hit_way, vic_way_c, vic_dirty_c;
  logic              hit_inc, miss_inc;
  logic              lru_upd, lru_mru, lru_way_c;
  logic [DATA_W-1:0] resp_rdata_d;

  // Byte offset bits never select anything in a one-word line.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFF_W-1:0];

  assign arr_index = idx_q;

  cache_ctrl_lru u_lru (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx_q),
    .lru_way_c (lru_way_c),
    .upd_en    (lru_upd),
    .upd_idx   (idx_q),
    .mru_way   (lru_mru)
  );

  // Next-state, array write port, LRU update and victim selection
  always_comb begin
    next_state     = state;
    hit0           = v_way0 && (tag_way0 == tag_q);
    hit1           = v_way1 && (tag_way1 == tag_q);
    hit_way        = !hit0;
    vic_way_c      = pick_victim(v_way0, v_way1, lru_way_c);
    vic_dirty_c    = vic_way_c ? (v_way1 && dirty_way1) : (v_way0 && dirty_way0);
    vic_way_d      = vic_way_q;
    vic_tag_d      = vic_tag_q;
    vic_data_d     = vic_data_q;
    resp_rdata_d   = '0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    lru_upd        = 1'b0;
    lru_mru        = 1'b0;
    arr_write_en   = 1'b0;
    arr_victim_way = 1'b0;
    arr_v_in       = 1'b0;
    arr_dirty_in   = 1'b0;
    arr_tag_in     = '0;
    arr_data_in    = '0;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit0 || hit1) begin
          hit_inc    = 1'b1;
          lru_upd    = 1'b1;
          lru_mru    = hit_way;
          next_state = S_RESP;
          if (we_q) begin
            arr_write_en   = 1'b1;
            arr_victim_way = hit_way;
            arr_v_in       = 1'b1;
            arr_dirty_in   = 1'b1;
            arr_tag_in     = tag_q;
            arr_data_in    = wdata_q;
          end else begin
            resp_rdata_d = hit_way ? data_way1 : data_way0;
          end
        end else begin
          miss_inc   = 1'b1;
          vic_way_d  = vic_way_c;
          vic_tag_d  = vic_way_c ? tag_way1 : tag_way0;
          vic_data_d = vic_way_c ? data_way1 : data_way0;
          if (vic_dirty_c) next_state = S_WB;
          else if (we_q)   next_state = S_FILL;
          else             next_state = S_REFILL;
        end
      end
      S_WB: begin
        if (mem_req_ready) next_state = we_q ? S_FILL : S_REFILL;
      end
      S_REFILL: begin
        if (mem_req_ready) next_state = S_RWAIT;
      end
      S_RWAIT: begin
        if (mem_resp_valid) next_state = S_FILL;
      end
      S_FILL: begin
        arr_write_en   = 1'b1;
        arr_victim_way = vic_way_q;
        arr_v_in       = 1'b1;
        arr_dirty_in   = we_q;
        arr_tag_in     = tag_q;
        arr_data_in    = we_q ? wdata_q : refill_q;
        lru_upd        = 1'b1;
        lru_mru        = vic_way_q;
        resp_rdata_d   = we_q ? '0 : refill_q;
        next_state     = S_RESP;
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    // Reset pre-empts any in-flight array or LRU update.
    if (rst) begin
      arr_write_en = 1'b0;
      lru_upd      = 1'b0;
    end
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      tag_q         <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      vic_way_q     <= 1'b0;
      vic_tag_q     <= '0;
      vic_data_q    <= '0;
      refill_q      <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      state      <= next_state;
      vic_way_q  <= vic_way_d;
      vic_tag_q  <= vic_tag_d;
      vic_data_q <= vic_data_d;

      if (state == S_IDLE && req_valid && req_ready) begin
        we_q    <= req_we;
        tag_q   <= req_addr[ADDR_W-1:TAG_LSB];
        idx_q   <= req_addr[TAG_LSB-1:OFF_W];
        wdata_q <= req_wdata;
      end

      if (state == S_RWAIT && mem_resp_valid) refill_q <= mem_rdata;

      req_ready  <= (next_state == S_IDLE);
      resp_valid <= (next_state == S_RESP);
      resp_rdata <= resp_rdata_d;

      // Driven from next-state so the request holds steady across memory stalls.
      mem_req_valid <= (next_state == S_WB) || (next_state == S_REFILL);
      mem_we        <= (next_state == S_WB);
      case (next_state)
        S_WB: begin
          mem_addr  <= {vic_tag_d, idx_q, OFF_W'(0)};
          mem_wdata <= vic_data_d;
        end
        S_REFILL: begin
          mem_addr  <= {tag_q, idx_q, OFF_W'(0)};
          mem_wdata <= '0;
        end
        default: begin
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
      endcase

      if (hit_inc && hit_cnt != {CNT_W{1'b1}})   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_inc && miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench: cache_ctrl with a behavioural cache array and a stalling memory model.
module tb_cache_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TAG_W  = 28;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req_valid, mem_we;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              arr_write_en, arr_victim_way, arr_v_in, arr_dirty_in;
  logic [1:0]        arr_index;
  logic [TAG_W-1:0]  arr_tag_in;
  logic [DATA_W-1:0] arr_data_in;
  logic              v_way0, v_way1, dirty_way0, dirty_way1;
  logic [TAG_W-1:0]  tag_way0, tag_way1;
  logic [DATA_W-1:0] data_way0, data_way1;
  logic [31:0]       hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  cache_ctrl #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .arr_write_en(arr_write_en), .arr_index(arr_index), .arr_victim_way(arr_victim_way),
    .arr_v_in(arr_v_in), .arr_dirty_in(arr_dirty_in), .arr_tag_in(arr_tag_in),
    .arr_data_in(arr_data_in),
    .v_way0(v_way0), .v_way1(v_way1), .dirty_way0(dirty_way0), .dirty_way1(dirty_way1),
    .tag_way0(tag_way0), .tag_way1(tag_way1), .data_way0(data_way0), .data_way1(data_way1),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Behavioural cache array: combinational read of arr_index, write on clock edge.
  logic [1:0][3:0]   a_v = '0;
  logic [1:0][3:0]   a_d = '0;
  logic [TAG_W-1:0]  a_tag  [2][4];
  logic [DATA_W-1:0] a_data [2][4];

  always @(posedge clk) begin
    if (arr_write_en) begin
      a_v[arr_victim_way][arr_index]    <= arr_v_in;
      a_d[arr_victim_way][arr_index]    <= arr_dirty_in;
      a_tag[arr_victim_way][arr_index]  <= arr_tag_in;
      a_data[arr_victim_way][arr_index] <= arr_data_in;
    end
  end

  assign v_way0     = a_v[0][arr_index];
  assign v_way1     = a_v[1][arr_index];
  assign dirty_way0 = a_d[0][arr_index];
  assign dirty_way1 = a_d[1][arr_index];
  assign tag_way0   = a_tag[0][arr_index];
  assign tag_way1   = a_tag[1][arr_index];
  assign data_way0  = a_data[0][arr_index];
  assign data_way1  = a_data[1][arr_index];

  // Memory model: handshake captured at posedge, serviced at the following negedge.
  logic        hs = 1'b0;
  logic        hs_we = 1'b0;
  logic [31:0] hs_addr = '0;
  logic [31:0] hs_data = '0;
  logic [31:0] mem [64];
  logic        mem_inited = 1'b0;
  logic        resp_pend = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = '0;
  int          resp_lat = 2;
  logic        stall_force = 1'b0;
  logic        log_we [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  always @(posedge clk) begin
    hs      <= mem_req_valid && mem_req_ready;
    hs_we   <= mem_we;
    hs_addr <= mem_addr;
    hs_data <= mem_wdata;
  end

  always @(negedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      mem[4]  = 32'hDEAD_BEEF;
      mem[8]  = 32'hAAAA_0020;
      mem[12] = 32'hBBBB_0030;
      mem[20] = 32'h5050_5050;
      mem[24] = 32'h6060_6060;
      mem_inited = 1'b1;
    end
    if (hs) begin
      log_we.push_back(hs_we);
      log_addr.push_back(hs_addr);
      log_data.push_back(hs_data);
      if (hs_we) begin
        mem[hs_addr[7:2]] = hs_data;
      end else begin
        resp_pend = 1'b1;
        resp_cnt  = resp_lat;
        resp_data = mem[hs_addr[7:2]];
      end
    end
    mem_resp_valid = 1'b0;
    if (resp_pend) begin
      if (resp_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = resp_data;
        resp_pend      = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    mem_req_ready = !stall_force && ($urandom_range(0, 3) != 0);
  end

  // Response scoreboard and array-write/memory-request exclusivity
  logic [31:0] exp_q [$];

  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: rdata=%h, no response was expected", resp_rdata);
      end else begin
        logic [31:0] exp_v;
        exp_v = exp_q.pop_front();
        if (resp_rdata !== exp_v) begin
          errors++;
          $display("FAIL resp_rdata: got %h, expected %h", resp_rdata, exp_v);
        end
      end
    end
    if (rst === 1'b0) begin
      checks++;
      if (arr_write_en && mem_req_valid) begin
        errors++;
        $display("FAIL wr_vs_mem: arr_write_en=%b mem_req_valid=%b, expected not both", arr_write_en, mem_req_valid);
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, output int lat);
    int n;
    exp_q.push_back(exp_rdata);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (resp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: addr=%h got no resp_valid within %0d cycles", addr, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || arr_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b resp=%b memv=%b wr=%b, expected all 0",
               req_ready, resp_valid, mem_req_valid, arr_write_en);
    end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d, expected 0/0", hit_cnt, miss_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, expected 1", req_ready);
    end
  endtask

  task automatic test_cold_load();
    int lat;
    do_req(1'b0, 32'h10, '0, 32'hDEAD_BEEF, lat);
    checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL cold_cnt: hit=%0d miss=%0d, expected 0/1", hit_cnt, miss_cnt);
    end
    checks++;
    if (log_we.size() != 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h10) begin
      errors++;
      $display("FAIL cold_refill: %0d mem txns, expected one refill read of 0x10", log_we.size());
    end
    do_req(1'b0, 32'h10, '0, 32'hDEAD_BEEF, lat);
    checks++;
    if (lat != 2 || hit_cnt !== 32'd1) begin
      errors++;
      $display("FAIL cold_hit: latency=%0d hit=%0d, expected 2/1", lat, hit_cnt);
    end
  endtask

  task automatic test_store_hit();
    int lat;
    do_req(1'b1, 32'h10, 32'h1234_5678, 32'h0, lat);
    checks++;
    if (lat != 2 || a_d[0][0] !== 1'b1 || a_data[0][0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_hit: latency=%0d dirty=%b data=%h, expected 2/1/12345678",
               lat, a_d[0][0], a_data[0][0]);
    end
    do_req(1'b0, 32'h10, '0, 32'h1234_5678, lat);
    checks++;
    if (log_we.size() != 1 || hit_cnt !== 32'd3) begin
      errors++;
      $display("FAIL store_hit_traffic: mem txns=%0d hit=%0d, expected 1/3", log_we.size(), hit_cnt);
    end
  endtask

  task automatic test_evict();
    int lat;
    do_req(1'b0, 32'h20, '0, 32'hAAAA_0020, lat);
    do_req(1'b0, 32'h30, '0, 32'hBBBB_0030, lat);
    checks++;
    if (log_we.size() != 4 || log_we[2] !== 1'b1 || log_addr[2] !== 32'h10 || log_data[2] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL evict_wb: txns=%0d, expected writeback 0x10/12345678 as third txn", log_we.size());
    end
    checks++;
    if (log_we.size() != 4 || log_we[3] !== 1'b0 || log_addr[3] !== 32'h30) begin
      errors++;
      $display("FAIL evict_refill: txns=%0d, expected refill of 0x30 after writeback", log_we.size());
    end
    checks++;
    if (miss_cnt !== 32'd3 || mem[4] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL evict_state: miss=%0d mem[0x10]=%h, expected 3/12345678", miss_cnt, mem[4]);
    end
  endtask

  task automatic test_store_miss_invalid();
    int lat;
    int n0;
    n0 = log_we.size();
    do_req(1'b1, 32'h44, 32'hCAFE_F00D, 32'h0, lat);
    checks++;
    if (lat != 3 || log_we.size() != n0) begin
      errors++;
      $display("FAIL store_miss_lat: latency=%0d new txns=%0d, expected 3/0", lat, log_we.size() - n0);
    end
    checks++;
    if (a_v[0][1] !== 1'b1 || a_d[0][1] !== 1'b1 || a_tag[0][1] !== 28'h4 || a_data[0][1] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL store_miss_line: v=%b d=%b tag=%h data=%h, expected 1/1/4/cafef00d",
               a_v[0][1], a_d[0][1], a_tag[0][1], a_data[0][1]);
    end
  endtask

  task automatic test_wb_stall();
    int lat;
    do_req(1'b1, 32'h30, 32'h5555_AAAA, 32'h0, lat);
    do_req(1'b0, 32'h20, '0, 32'hAAAA_0020, lat);
    stall_force = 1'b1;
    fork
      do_req(1'b0, 32'h50, '0, 32'h5050_5050, lat);
      begin
        int n;
        logic [31:0] a0, d0;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 30) begin
          @(negedge clk);
          n++;
        end
        a0 = mem_addr;
        d0 = mem_wdata;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || a0 !== 32'h30 || d0 !== 32'h5555_AAAA) begin
          errors++;
          $display("FAIL wb_req: valid=%b we=%b addr=%h data=%h, expected 1/1/30/5555aaaa",
                   mem_req_valid, mem_we, a0, d0);
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++;
          if (mem_req_valid !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wb_stall: cycle %0d valid=%b addr=%h data=%h ready=%b, expected 1/%h/%h/0",
                     i, mem_req_valid, mem_addr, mem_wdata, req_ready, a0, d0);
          end
        end
        stall_force = 1'b0;
      end
    join
    checks++;
    if (miss_cnt !== 32'd5 || hit_cnt !== 32'd5) begin
      errors++;
      $display("FAIL wb_stall_cnt: hit=%0d miss=%0d, expected 5/5", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_rst_rwait();
    int n;
    int lat;
    resp_lat = 20;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h60; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    n = 0;
    while (mem_req_valid !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || arr_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_rwait: ready=%b memv=%b resp=%b wr=%b, expected all 0",
               req_ready, mem_req_valid, resp_valid, arr_write_en);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_release: ready=%b hit=%0d miss=%0d, expected 1/0/0", req_ready, hit_cnt, miss_cnt);
    end
    repeat (25) @(negedge clk);
    resp_lat = 2;
    checks++;
    if (a_tag[1][0] !== 28'h2 || a_data[1][0] !== 32'hAAAA_0020) begin
      errors++;
      $display("FAIL rst_line: tag=%h data=%h, expected 2/aaaa0020", a_tag[1][0], a_data[1][0]);
    end
    do_req(1'b0, 32'h20, '0, 32'hAAAA_0020, lat);
    checks++;
    if (lat != 2 || hit_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rst_after_hit: latency=%0d hit=%0d, expected 2/1", lat, hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_store_miss_invalid();
    test_wb_stall();
    test_rst_rwait();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
